// File: rtl/switch_sequence_reader_if.sv
// Bus between the game state machine and the switch sequence reader:
// start/length/expected sequence in, press events and pass/fail status out.
interface switch_sequence_reader_if #(
  parameter int GAME_LIMIT = 7
);
  logic [3:0]              i_sw;
  logic                    i_start;
  logic [3:0]              i_len;
  logic [2*GAME_LIMIT-1:0] i_expected;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_pass;
  logic                    o_fail;
  logic [3:0]              o_count;
  logic                    o_press_valid;
  logic [1:0]              o_press_idx;

  modport master (
    output i_sw, i_start, i_len, i_expected,
    input  o_busy, o_done, o_pass, o_fail, o_count, o_press_valid, o_press_idx
  );

  modport slave (
    input  i_sw, i_start, i_len, i_expected,
    output o_busy, o_done, o_pass, o_fail, o_count, o_press_valid, o_press_idx
  );
endinterface

// File: rtl/switch_sequence_reader.sv
// Turns debounced switch levels into press events and checks them against the expected
// LED sequence. Define SEQ_READER_TIMEOUT_EN to build the inactivity timeout in ARMED.
module switch_sequence_reader #(
  parameter int GAME_LIMIT  = 7,
  parameter int CLK_PER_SEC = 50000000,
  parameter int TIMEOUT_SEC = 5
) (
  input logic                    i_clk,
  input logic                    i_rst,
  switch_sequence_reader_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RELEASE = 3'd1;
  localparam logic [2:0] ARMED   = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]              state, state_d;
  logic [3:0]              sw_q, rise, len_q, count;
  logic [2*GAME_LIMIT-1:0] exp_q;
  logic [1:0]              rise_idx, exp_entry, press_idx_q;
  logic                    busy_q, done_q, pass_q, fail_q, press_valid_q;
  logic                    is_press, start_acc, count_inc, take_press;
  logic                    set_pass, set_fail, timed_out, enter_done;

  // A press is a single fresh rise with no other switch still held.
  assign rise       = bus.i_sw & ~sw_q;
  assign is_press   = $onehot(rise) && (bus.i_sw == rise);
  assign exp_entry  = 2'(exp_q >> {count, 1'b0});
  assign enter_done = (state_d == DONE) && (state != DONE);

  always_comb begin
    rise_idx = 2'd0;
    case (rise)
      4'b0010: rise_idx = 2'd1;
      4'b0100: rise_idx = 2'd2;
      4'b1000: rise_idx = 2'd3;
      default: rise_idx = 2'd0;
    endcase
  end

`ifdef SEQ_READER_TIMEOUT_EN
  localparam int TIMEOUT_LIMIT = CLK_PER_SEC * TIMEOUT_SEC;
  localparam int TMR_W         = $clog2(TIMEOUT_LIMIT + 1);

  logic [TMR_W-1:0] tmr;

  // Runs only while ARMED stays ARMED, so entering ARMED or accepting a press restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      tmr <= '0;
    else if (state != ARMED || state_d != ARMED)
      tmr <= '0;
    else if (tmr != TMR_W'(TIMEOUT_LIMIT))
      tmr <= tmr + 1'b1;
  end

  assign timed_out = (tmr == TMR_W'(TIMEOUT_LIMIT));
`else
  localparam int unused_timeout_cfg = CLK_PER_SEC + TIMEOUT_SEC;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    start_acc  = 1'b0;
    count_inc  = 1'b0;
    take_press = 1'b0;
    set_pass   = 1'b0;
    set_fail   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          start_acc = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (bus.i_sw == 4'd0) begin
          if (len_q == 4'd0) begin
            set_pass = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = ARMED;
          end
        end
      end
      ARMED: begin
        if (rise != 4'd0) begin
          if (is_press) begin
            take_press = 1'b1;
            if (rise_idx == exp_entry) begin
              count_inc = 1'b1;
              state_d   = HOLD;
            end else begin
              set_fail  = 1'b1;
              state_d   = DONE;
            end
          end else begin
            set_fail = 1'b1;
            state_d  = DONE;
          end
        end else if (timed_out) begin
          set_fail = 1'b1;
          state_d  = DONE;
        end
      end
      HOLD: begin
        if (rise != 4'd0) begin
          set_fail = 1'b1;
          state_d  = DONE;
        end else if (bus.i_sw == 4'd0) begin
          if (count == len_q) begin
            set_pass = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = ARMED;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pass/fail are sticky until the next accepted start so the game can read them late.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      sw_q          <= 4'd0;
      len_q         <= 4'd0;
      exp_q         <= '0;
      count         <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      press_valid_q <= 1'b0;
      press_idx_q   <= 2'd0;
    end else begin
      state         <= state_d;
      sw_q          <= bus.i_sw;
      done_q        <= enter_done;
      press_valid_q <= take_press;
      if (take_press)
        press_idx_q <= rise_idx;
      if (start_acc) begin
        len_q  <= (bus.i_len > 4'(GAME_LIMIT)) ? 4'(GAME_LIMIT) : bus.i_len;
        exp_q  <= bus.i_expected;
        count  <= 4'd0;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
        busy_q <= 1'b1;
      end else if (enter_done) begin
        busy_q <= 1'b0;
      end
      if (count_inc && count != 4'(GAME_LIMIT))
        count <= count + 1'b1;
      if (set_pass)
        pass_q <= 1'b1;
      if (set_fail)
        fail_q <= 1'b1;
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_pass        = pass_q;
  assign bus.o_fail        = fail_q;
  assign bus.o_count       = count;
  assign bus.o_press_valid = press_valid_q;
  assign bus.o_press_idx   = press_idx_q;

endmodule
